// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  // Controller state encoding; the numeric values appear on the state port.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  // Width of the internal memory-wait cycle counter.
  localparam int WAIT_W = 8;

  // Default width of the performance counters.
  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: freezes and flushes for memory stalls, taken branches
// and data hazards, with a memory-timeout error state and two saturating
// performance counters. Control outputs are combinational from the
// registered state and the current inputs.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_freeze,
  output logic             if_freeze,
  output logic             if_flush,
  output logic             id_flush,
  output logic             back_freeze,
  output logic             err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t            cur_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_stall;
  state_t            eff_state;

  assign mem_stall = mem_req && !mem_ready;
  // Reset forces the outputs to follow the RUN rules in the same cycle.
  assign eff_state = rst ? RUN : cur_state;

  // Control decode: mem_stall > branch_taken > hazard while running.
  always_comb begin
    pc_freeze   = 1'b0;
    if_freeze   = 1'b0;
    if_flush    = 1'b0;
    id_flush    = 1'b0;
    back_freeze = 1'b0;
    case (eff_state)
      RUN, MEM_WAIT: begin
        // In MEM_WAIT the only stall source is the outstanding access.
        if ((eff_state == RUN) ? mem_stall : !mem_ready) begin
          pc_freeze   = 1'b1;
          if_freeze   = 1'b1;
          back_freeze = 1'b1;
        end else if (branch_taken) begin
          if_flush = 1'b1;
          id_flush = 1'b1;
        end else if (hazard) begin
          pc_freeze = 1'b1;
          if_freeze = 1'b1;
          id_flush  = 1'b1;
        end
      end
      default: begin
        pc_freeze   = 1'b1;
        if_freeze   = 1'b1;
        back_freeze = 1'b1;
      end
    endcase
  end

  // State and wait-cycle tracking; ERROR is left only through rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= RUN;
      wait_cnt  <= '0;
    end else begin
      case (cur_state)
        RUN: begin
          if (mem_stall) begin
            cur_state <= MEM_WAIT;
            wait_cnt  <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            cur_state <= RUN;
            wait_cnt  <= '0;
          end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
            cur_state <= ERROR;
            wait_cnt  <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          cur_state <= ERROR;
          wait_cnt  <= '0;
        end
      endcase
    end
  end

  assign state = cur_state;
  assign err   = (cur_state == ERROR);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_freeze),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (if_flush),
    .count (flush_cnt)
  );

endmodule
